// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: control FSM for the multicycle RV32I core, with optional
// ready-based memory handshake, optional mul/div path and a reset-only HALT state.
module multicycle_ctrl_fsm #(
   parameter bit MEM_HANDSHAKE = 1'b0,
   parameter bit ENABLE_M      = 1'b0,
   parameter bit ILLEGAL_HALTS = 1'b1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       mem_ready,
   input  logic       md_done,
   output logic       pc_write,
   output logic       ir_write,
   output logic       pc_src,
   output logic       reg_write,
   output logic       imm,
   output logic       mem_write,
   output logic       branch,
   output logic [1:0] adr_src,
   output logic [1:0] alu_op,
   output logic [2:0] alu_src_a,
   output logic [2:0] alu_src_b,
   output logic [2:0] result_src,
   output logic       mem_req,
   output logic       md_start,
   output logic       halted,
   output logic       illegal,
   output logic [4:0] state_o
);
   typedef enum logic [4:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECUTER, EXECUTEI,
      MULDIV, ALUWB, JAL, JALR, BRANCH, AUIPC, LUI, HALT
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   from_md_q, from_md_d;
   logic   mem_done;
   logic   unused_funct3;

   assign unused_funct3 = ^funct3;
   assign mem_done      = !MEM_HANDSHAKE || mem_ready;
   assign from_md_d     = state_q == MULDIV;
   assign state_o       = state_q;
   assign illegal       = illegal_q;

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         FETCH:    state_d = mem_done ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_R:      state_d = (ENABLE_M && funct7 == F7_MULDIV) ? MULDIV : EXECUTER;
               OP_I:      state_d = EXECUTEI;
               OP_JAL:    state_d = JAL;
               OP_JALR:   state_d = JALR;
               OP_BRANCH: state_d = BRANCH;
               OP_AUIPC:  state_d = AUIPC;
               OP_LUI:    state_d = LUI;
               OP_SYSTEM: state_d = HALT;
               default: begin
                  state_d   = ILLEGAL_HALTS ? HALT : FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEMADR:   state_d = (op == OP_LOAD) ? MEMREAD : MEMWR;
         MEMREAD:  state_d = mem_done ? MEMWB : MEMREAD;
         MEMWR:    state_d = mem_done ? FETCH : MEMWR;
         MULDIV:   state_d = md_done ? ALUWB : MULDIV;
         MEMWB, ALUWB, JAL, BRANCH:            state_d = FETCH;
         EXECUTER, EXECUTEI, JALR, AUIPC, LUI: state_d = ALUWB;
         default:  state_d = HALT;
      endcase
   end

   // from_md_q doubles as "previous cycle was MULDIV": it gates the launch pulse
   // and selects the mul/div result in ALUWB.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
         from_md_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         from_md_q <= from_md_d;
      end
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      imm        = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      adr_src    = 2'b00;
      alu_op     = 2'b00;
      alu_src_a  = 3'b000;
      alu_src_b  = 3'b000;
      result_src = 3'b000;
      mem_req    = 1'b0;
      md_start   = 1'b0;
      halted     = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 3'b001;
            ir_write  = mem_done;
            pc_write  = mem_done;
         end
         DECODE: begin
            alu_src_a = 3'b010;
            alu_src_b = 3'b010;
         end
         MEMADR: begin
            alu_src_a = 3'b001;
            alu_src_b = 3'b010;
         end
         MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 2'b01;
         end
         MEMWR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 2'b01;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            result_src = 3'b001;
         end
         EXECUTER: begin
            alu_src_a = 3'b001;
            alu_op    = 2'b10;
         end
         EXECUTEI: begin
            alu_src_a = 3'b001;
            alu_src_b = 3'b010;
            alu_op    = 2'b10;
            imm       = 1'b1;
         end
         MULDIV:   md_start = !from_md_q;
         ALUWB: begin
            reg_write  = 1'b1;
            result_src = from_md_q ? 3'b011 : 3'b000;
         end
         JAL: begin
            alu_src_a  = 3'b010;
            alu_src_b  = 3'b001;
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            reg_write  = 1'b1;
            result_src = 3'b010;
         end
         JALR: begin
            alu_src_a = 3'b010;
            alu_src_b = 3'b001;
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            imm       = 1'b1;
         end
         BRANCH: begin
            alu_src_a = 3'b001;
            alu_op    = 2'b01;
            branch    = 1'b1;
            pc_src    = 1'b1;
         end
         AUIPC: begin
            alu_src_a = 3'b010;
            alu_src_b = 3'b010;
         end
         LUI: begin
            alu_src_a = 3'b011;
            alu_src_b = 3'b010;
         end
         HALT:     halted = 1'b1;
         default:  ;
      endcase
   end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed vector table plus randomized run of all eight
// parameter combinations against a per-instruction phase-list reference model.
module tb_multicycle_ctrl_fsm;
   localparam int N = 8;
   localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                  P_MEMWR = 5, P_EXECUTER = 6, P_EXECUTEI = 7, P_MULDIV = 8, P_ALUWB = 9,
                  P_JAL = 10, P_JALR = 11, P_BRANCH = 12, P_AUIPC = 13, P_LUI = 14,
                  P_HALT = 15, P_ALUWB_MD = 16;
   localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                          OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                          OP_BR = 7'b1100011, OP_AUIPC = 7'b0010111, OP_LUI = 7'b0110111,
                          OP_SYS = 7'b1110011, OP_BAD = 7'b1111111;
   localparam logic [6:0] F0 = 7'b0000000, FM = 7'b0000001;

   typedef struct packed {
      logic       pc_write, ir_write, pc_src, reg_write, imm, mem_write, branch;
      logic [1:0] adr_src, alu_op;
      logic [2:0] alu_src_a, alu_src_b, result_src;
      logic       mem_req, md_start, halted, illegal;
      logic [4:0] state;
   } outs_t;

   typedef struct {
      int         inst;
      logic       rstn;
      logic [6:0] op, f7;
      logic       mr, mdd, chk;
      logic [13:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       resetn [N];
   logic [6:0] op [N];
   logic [2:0] funct3 [N];
   logic [6:0] funct7 [N];
   logic       mem_ready [N];
   logic       md_done [N];
   outs_t      o [N];
   int         checks = 0, errors = 0;

   int path [N][6];
   int len [N], pos [N], dwell [N];
   bit ill [N];
   logic [6:0] ops [10] = '{OP_LOAD, OP_STORE, OP_R, OP_R, OP_I, OP_JAL, OP_JALR, OP_BR, OP_AUIPC, OP_LUI};
   vec_t tbl [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      outs_t ob;
      multicycle_ctrl_fsm #(
         .MEM_HANDSHAKE(bit'(g % 2)),
         .ENABLE_M     (bit'((g / 2) % 2)),
         .ILLEGAL_HALTS(bit'(g / 4))
      ) u_dut (
         .clk(clk), .resetn(resetn[g]), .op(op[g]), .funct3(funct3[g]), .funct7(funct7[g]),
         .mem_ready(mem_ready[g]), .md_done(md_done[g]),
         .pc_write(ob.pc_write), .ir_write(ob.ir_write), .pc_src(ob.pc_src),
         .reg_write(ob.reg_write), .imm(ob.imm), .mem_write(ob.mem_write), .branch(ob.branch),
         .adr_src(ob.adr_src), .alu_op(ob.alu_op), .alu_src_a(ob.alu_src_a),
         .alu_src_b(ob.alu_src_b), .result_src(ob.result_src), .mem_req(ob.mem_req),
         .md_start(ob.md_start), .halted(ob.halted), .illegal(ob.illegal), .state_o(ob.state)
      );
      assign o[g] = ob;
   end

   function automatic vec_t mk(int inst, int rstn, logic [6:0] opc, logic [6:0] f7, int mr, int mdd,
                               int chk, int st, int rs, int rw, int irw, int mw, int mds,
                               int hlt, int il, int mreq);
      vec_t v;
      v.inst = inst; v.rstn = 1'(rstn); v.op = opc; v.f7 = f7;
      v.mr = 1'(mr); v.mdd = 1'(mdd); v.chk = 1'(chk);
      v.exp = {5'(st), 3'(rs), 1'(rw), 1'(irw), 1'(mw), 1'(mds), 1'(hlt), 1'(il), 1'(mreq)};
      return v;
   endfunction

   // Expected outputs for one phase, straight from the state output table.
   function automatic outs_t expect_out(int ph, bit mh, bit ready, bit first, bit il);
      outs_t e = '0;
      e.state   = (ph == P_ALUWB_MD) ? 5'd9 : 5'(ph);
      e.illegal = il;
      case (ph)
         P_FETCH:    begin e.mem_req = 1; e.alu_src_b = 3'b001; e.ir_write = !mh || ready; e.pc_write = !mh || ready; end
         P_DECODE:   begin e.alu_src_a = 3'b010; e.alu_src_b = 3'b010; end
         P_MEMADR:   begin e.alu_src_a = 3'b001; e.alu_src_b = 3'b010; end
         P_MEMREAD:  begin e.mem_req = 1; e.adr_src = 2'b01; end
         P_MEMWB:    begin e.reg_write = 1; e.result_src = 3'b001; end
         P_MEMWR:    begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 2'b01; end
         P_EXECUTER: begin e.alu_src_a = 3'b001; e.alu_op = 2'b10; end
         P_EXECUTEI: begin e.alu_src_a = 3'b001; e.alu_src_b = 3'b010; e.alu_op = 2'b10; e.imm = 1; end
         P_MULDIV:   e.md_start = first;
         P_ALUWB:    e.reg_write = 1;
         P_ALUWB_MD: begin e.reg_write = 1; e.result_src = 3'b011; end
         P_JAL:      begin e.alu_src_a = 3'b010; e.alu_src_b = 3'b001; e.pc_write = 1; e.pc_src = 1;
                           e.reg_write = 1; e.result_src = 3'b010; end
         P_JALR:     begin e.alu_src_a = 3'b010; e.alu_src_b = 3'b001; e.pc_write = 1; e.pc_src = 1; e.imm = 1; end
         P_BRANCH:   begin e.alu_src_a = 3'b001; e.alu_op = 2'b01; e.branch = 1; e.pc_src = 1; end
         P_AUIPC:    begin e.alu_src_a = 3'b010; e.alu_src_b = 3'b010; end
         P_LUI:      begin e.alu_src_a = 3'b011; e.alu_src_b = 3'b010; end
         P_HALT:     e.halted = 1;
         default:    ;
      endcase
      return e;
   endfunction

   function automatic void model_reset(int i);
      path[i][0] = P_FETCH;
      path[i][1] = P_DECODE;
      len[i] = 2; pos[i] = 0; dwell[i] = 0; ill[i] = 0;
   endfunction

   // Each instruction is FETCH, DECODE, then a tail chosen by opcode at decode time.
   function automatic void model_step(int i);
      int ph = path[i][pos[i]];
      bit mh = bit'(i % 2), em = bit'((i / 2) % 2), ih = bit'(i / 4);
      int t [3];
      int n = 0;
      if (!resetn[i]) begin
         model_reset(i);
         return;
      end
      if (ph == P_HALT || (mh && !mem_ready[i] && (ph == P_FETCH || ph == P_MEMREAD || ph == P_MEMWR))
          || (ph == P_MULDIV && !md_done[i])) begin
         dwell[i]++;
         return;
      end
      dwell[i] = 0;
      if (ph == P_DECODE) begin
         case (op[i])
            OP_LOAD:   begin t = '{P_MEMADR, P_MEMREAD, P_MEMWB}; n = 3; end
            OP_STORE:  begin t = '{P_MEMADR, P_MEMWR, 0}; n = 2; end
            OP_R:      begin
               t = (em && funct7[i] == FM) ? '{P_MULDIV, P_ALUWB_MD, 0} : '{P_EXECUTER, P_ALUWB, 0};
               n = 2;
            end
            OP_I:      begin t = '{P_EXECUTEI, P_ALUWB, 0}; n = 2; end
            OP_JAL:    begin t = '{P_JAL, 0, 0}; n = 1; end
            OP_JALR:   begin t = '{P_JALR, P_ALUWB, 0}; n = 2; end
            OP_BR:     begin t = '{P_BRANCH, 0, 0}; n = 1; end
            OP_AUIPC:  begin t = '{P_AUIPC, P_ALUWB, 0}; n = 2; end
            OP_LUI:    begin t = '{P_LUI, P_ALUWB, 0}; n = 2; end
            OP_SYS:    begin t = '{P_HALT, 0, 0}; n = 1; end
            default:   begin ill[i] = 1; t = '{P_HALT, 0, 0}; n = ih ? 1 : 0; end
         endcase
         for (int k = 0; k < n; k++) path[i][2 + k] = t[k];
         len[i] = 2 + n;
      end
      pos[i]++;
      if (pos[i] >= len[i]) begin
         pos[i] = 0;
         len[i] = 2;
      end
   endfunction

   function automatic void check(string name, int i, outs_t act, outs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d: got %h (state %0d) expected %h (state %0d)",
                  name, i, act, act.state, exp, exp.state);
      end
   endfunction

   initial begin
      vec_t  r;
      outs_t a;
      logic [13:0] act;
      for (int i = 0; i < N; i++) begin
         resetn[i] = 0; op[i] = '0; funct3[i] = '0; funct7[i] = '0; mem_ready[i] = 0; md_done[i] = 0;
      end
      // add, single-cycle memory: FETCH DECODE EXECUTER ALUWB
      tbl.push_back(mk(4, 0, OP_R, F0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(4, 1, OP_R, F0, 0, 0, 1, P_FETCH, 0, 0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4, 1, OP_R, F0, 0, 0, 1, P_DECODE, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(4, 1, OP_R, F0, 0, 0, 1, P_EXECUTER, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(4, 1, OP_R, F0, 0, 0, 1, P_ALUWB, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(4, 1, OP_R, F0, 0, 0, 1, P_FETCH, 0, 0, 1, 0, 0, 0, 0, 1));
      // lw with handshake: 2 wait cycles in FETCH, 3 in MEMREAD, 10 cycles total
      tbl.push_back(mk(5, 0, OP_LOAD, F0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(5, 1, OP_LOAD, F0, 0, 0, 1, P_FETCH, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(5, 1, OP_LOAD, F0, 0, 0, 1, P_FETCH, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(5, 1, OP_LOAD, F0, 1, 0, 1, P_FETCH, 0, 0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(5, 1, OP_LOAD, F0, 1, 0, 1, P_DECODE, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(5, 1, OP_LOAD, F0, 1, 0, 1, P_MEMADR, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(5, 1, OP_LOAD, F0, 0, 0, 1, P_MEMREAD, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(5, 1, OP_LOAD, F0, 0, 0, 1, P_MEMREAD, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(5, 1, OP_LOAD, F0, 0, 0, 1, P_MEMREAD, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(5, 1, OP_LOAD, F0, 1, 0, 1, P_MEMREAD, 0, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(5, 1, OP_LOAD, F0, 0, 0, 1, P_MEMWB, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(5, 1, OP_LOAD, F0, 0, 0, 1, P_FETCH, 0, 0, 0, 0, 0, 0, 0, 1));
      // mul with ENABLE_M=1, md_done on the fifth MULDIV cycle; md_done elsewhere ignored
      tbl.push_back(mk(6, 0, OP_R, FM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(6, 1, OP_R, FM, 0, 1, 1, P_FETCH, 0, 0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(6, 1, OP_R, FM, 0, 1, 1, P_DECODE, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(6, 1, OP_R, FM, 0, 0, 1, P_MULDIV, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(6, 1, OP_R, FM, 0, 0, 1, P_MULDIV, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(6, 1, OP_R, FM, 0, 0, 1, P_MULDIV, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(6, 1, OP_R, FM, 0, 0, 1, P_MULDIV, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(6, 1, OP_R, FM, 0, 1, 1, P_MULDIV, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(6, 1, OP_R, FM, 0, 0, 1, P_ALUWB, 3, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(6, 1, OP_R, FM, 0, 0, 1, P_FETCH, 0, 0, 1, 0, 0, 0, 0, 1));
      // same mul encoding with ENABLE_M=0 is a plain R-type
      tbl.push_back(mk(4, 0, OP_R, FM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(4, 1, OP_R, FM, 0, 1, 1, P_FETCH, 0, 0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4, 1, OP_R, FM, 0, 1, 1, P_DECODE, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(4, 1, OP_R, FM, 0, 1, 1, P_EXECUTER, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(4, 1, OP_R, FM, 0, 1, 1, P_ALUWB, 0, 1, 0, 0, 0, 0, 0, 0));
      // illegal opcode with ILLEGAL_HALTS=0, then an add; illegal stays sticky
      tbl.push_back(mk(1, 0, OP_BAD, F0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, OP_BAD, F0, 1, 0, 1, P_FETCH, 0, 0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, OP_BAD, F0, 1, 0, 1, P_DECODE, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, OP_R, F0, 1, 0, 1, P_FETCH, 0, 0, 1, 0, 0, 0, 1, 1));
      tbl.push_back(mk(1, 1, OP_R, F0, 1, 0, 1, P_DECODE, 0, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 1, OP_R, F0, 1, 0, 1, P_EXECUTER, 0, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 1, OP_R, F0, 1, 0, 1, P_ALUWB, 0, 1, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 1, OP_R, F0, 0, 0, 1, P_FETCH, 0, 0, 0, 0, 0, 0, 1, 1));
      // store with handshake, reset during the MEMWR wait abandons the write
      tbl.push_back(mk(3, 0, OP_STORE, F0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3, 1, OP_STORE, F0, 1, 0, 1, P_FETCH, 0, 0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(3, 1, OP_STORE, F0, 0, 0, 1, P_DECODE, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3, 1, OP_STORE, F0, 0, 0, 1, P_MEMADR, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(3, 1, OP_STORE, F0, 0, 0, 1, P_MEMWR, 0, 0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(3, 0, OP_STORE, F0, 0, 0, 1, P_MEMWR, 0, 0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(3, 1, OP_STORE, F0, 0, 0, 1, P_FETCH, 0, 0, 0, 0, 0, 0, 0, 1));

      repeat (2) @(posedge clk);
      for (int k = 0; k < tbl.size(); k++) begin
         r = tbl[k];
         @(posedge clk); #1;
         resetn[r.inst] = r.rstn; op[r.inst] = r.op; funct7[r.inst] = r.f7;
         mem_ready[r.inst] = r.mr; md_done[r.inst] = r.mdd;
         @(negedge clk);
         if (r.chk) begin
            a = o[r.inst];
            act = {a.state, a.result_src, a.reg_write, a.ir_write, a.mem_write, a.md_start,
                   a.halted, a.illegal, a.mem_req};
            checks++;
            if (act !== r.exp) begin
               errors++;
               $display("FAIL vector%0d inst%0d: got %h expected %h", k, r.inst, act, r.exp);
            end
         end
      end

      // ecall halts with all enables low until reset
      @(posedge clk); #1; resetn[4] = 0;
      @(posedge clk); #1; resetn[4] = 1; op[4] = OP_SYS;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int k = 0; k < 20; k++) begin
         mem_ready[4] = 1'($urandom); md_done[4] = 1'($urandom);
         @(negedge clk);
         check("halt", 4, o[4], expect_out(P_HALT, 0, 0, 0, 0));
         @(posedge clk); #1;
      end
      resetn[4] = 0;
      @(posedge clk); #1; resetn[4] = 1;
      @(negedge clk);
      check("halt_reset", 4, o[4], expect_out(P_FETCH, 0, 1, 0, 0));

      @(posedge clk); #1;
      for (int i = 0; i < N; i++) resetn[i] = 0;
      @(posedge clk);
      for (int i = 0; i < N; i++) model_reset(i);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            resetn[i]    = ($urandom_range(0, 149) != 0);
            mem_ready[i] = ($urandom_range(0, 2) != 0);
            md_done[i]   = ($urandom_range(0, 3) == 0);
            funct3[i]    = 3'($urandom);
            if (path[i][pos[i]] == P_FETCH) begin
               int sel;
               sel = $urandom_range(0, 31);
               op[i] = (sel < 30) ? ops[sel % 10] : (sel == 30 ? OP_SYS : 7'($urandom));
               funct7[i] = $urandom_range(0, 1) ? FM : ($urandom_range(0, 1) ? 7'h20 : F0);
            end
         end
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            check("random", i, o[i], expect_out(path[i][pos[i]], bit'(i % 2), mem_ready[i],
                                                 dwell[i] == 0, ill[i]));
            model_step(i);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Parametrised control FSM for the multicycle RV32I core. It drives the existing datapath select and enable lines from a registered state. Compared with the current controller it adds three things: an optional ready-based memory handshake, an optional M-extension multi-cycle mul/div path, and a well-defined halt/illegal-instruction state that replaces simulation-only termination. It sits between the instruction register (op/funct fields) and the datapath muxes, register file, memory port and mul/div unit.

## Interface
- MEM_HANDSHAKE, 0: 1 = fetch and data accesses wait for `mem_ready`; 0 = memory is single-cycle and `mem_ready` is ignored.
- ENABLE_M, 0: 1 = R-type with funct7=0000001 is routed to the mul/div unit; 0 = decoded as plain R-type.
- ILLEGAL_HALTS, 1: 1 = unknown opcode enters HALT; 0 = unknown opcode is skipped (returns to FETCH).
- clk  in  1  clock. Reset is resetn, synchronous, active-low; clock clk.
- resetn  in  1  synchronous active-low reset.
- op  in  7  opcode from IR.
- funct3  in  3  from IR (passed through to the ALU decoder; not used for sequencing).
- funct7  in  7  from IR.
- mem_ready  in  1  memory access complete this cycle.
- md_done  in  1  mul/div result valid.
- pc_write, ir_write, pc_src, reg_write, imm, mem_write, branch  out  1 each  datapath enables.
- adr_src  out  2  00 = PC, 01 = ALUOut.
- alu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- alu_src_a  out  3  000 = PC, 001 = rs1, 010 = oldPC, 011 = zero.
- alu_src_b  out  3  000 = rs2, 001 = const 4, 010 = immediate.
- result_src  out  3  000 = ALUOut, 001 = memory data, 010 = ALU result, 011 = mul/div result.
- mem_req  out  1  memory access request.
- md_start  out  1  one-cycle mul/div launch pulse.
- halted  out  1  in HALT state.
- illegal  out  1  sticky flag: illegal opcode seen.
- state_o  out  5  current state, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECUTER, EXECUTEI, MULDIV, ALUWB, JAL, JALR, BRANCH, AUIPC, LUI, HALT.
- All outputs are combinational from state plus the handshake inputs. Every output defaults to 0 outside the states listed below.
- FETCH: mem_req=1, adr_src=00, alu_src_b=001. ir_write=pc_write=1 only when the access completes (always when MEM_HANDSHAKE=0; the mem_ready cycle otherwise). Stay in FETCH until then, then go to DECODE.
- DECODE: alu_src_a=010, alu_src_b=010 (branch target into ALUOut). Next state by opcode:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → MULDIV if ENABLE_M and funct7=0000001, else EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100111 → JALR
  - 1100011 → BRANCH
  - 0010111 → AUIPC
  - 0110111 → LUI
  - 1110011 → HALT
  - any other opcode → HALT with illegal set if ILLEGAL_HALTS, else FETCH with illegal still set.
- MEMADR: alu_src_a=001, alu_src_b=010. Next state MEMREAD for loads, MEMWR for stores.
- MEMREAD: mem_req=1, adr_src=01. Holds until complete, then MEMWB.
- MEMWR: mem_req=1, mem_write=1, adr_src=01. Holds until complete, then FETCH. mem_write stays high for the whole wait.
- MEMWB: reg_write=1, result_src=001, then FETCH.
- EXECUTER: alu_src_a=001, alu_op=10, then ALUWB.
- EXECUTEI: alu_src_a=001, alu_src_b=010, alu_op=10, imm=1, then ALUWB.
- MULDIV: md_start=1 on the first cycle in the state only. Wait for md_done (md_done on the entry cycle is accepted). Then ALUWB with result_src latched as 011.
- ALUWB: reg_write=1. result_src=011 if the state was entered from MULDIV, else 000. Next state FETCH.
- JAL: alu_src_a=010, alu_src_b=001, pc_write=1, pc_src=1, reg_write=1, result_src=010, then FETCH.
- JALR: alu_src_a=010, alu_src_b=001, pc_write=1, pc_src=1, imm=1, then ALUWB.
- BRANCH: alu_src_a=001, alu_op=01, branch=1, pc_src=1, then FETCH.
- AUIPC: alu_src_a=010, alu_src_b=010, then ALUWB.
- LUI: alu_src_a=011, alu_src_b=010, then ALUWB.
- HALT: halted=1, all enables 0. Leaves only via reset.

## Timing
- Reset: state=FETCH, illegal=0, MULDIV-origin flag=0. In the cycle after reset deasserts, outputs are the FETCH values (mem_req=1, ir_write=pc_write=1 when MEM_HANDSHAKE=0).
- Reset asserted in any state, including a mem or mul/div wait, takes effect at the next edge. No further md_start pulse is issued. A pending memory write is abandoned.
- Latency with MEM_HANDSHAKE=0, counted in cycles from FETCH:
  - branch, JAL: 3
  - store, R-type, I-type, JALR, AUIPC, LUI: 4
  - load: 5
  - mul/div: 4 + wait cycles
- With MEM_HANDSHAKE=1, each memory state adds one cycle per cycle mem_ready is low.
- mem_ready is sampled only in FETCH, MEMREAD and MEMWR. md_done is sampled only in MULDIV.

## Test plan
- MEM_HANDSHAKE=0, add (op=0110011, funct7=0) → states FETCH, DECODE, EXECUTER, ALUWB. reg_write=1 in cycle 4 only, with result_src=000.
- MEM_HANDSHAKE=1, lw with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD → 10 cycles total. ir_write pulses exactly once; reg_write=1 with result_src=001.
- ENABLE_M=1, mul (funct7=0000001), md_done after 5 cycles → md_start high for exactly 1 cycle, ALUWB result_src=011. With ENABLE_M=0 the same instruction takes the EXECUTER path.
- op=1110011 → HALT. halted=1, illegal=0, all enables 0 for 20 cycles. resetn low for 1 cycle → back to FETCH.
- op=1111111 with ILLEGAL_HALTS=0 → illegal=1, returns to FETCH after DECODE. A following add completes normally and illegal stays 1.
- resetn low during the MEMWR wait (MEM_HANDSHAKE=1) → the next cycle is FETCH with mem_write=0.
